// File: rtl/ahblite_uart_slave_pkg.sv
// Shared definitions for the AHB-lite UART responder: register offsets,
// STATUS bit positions and the TX/RX frame state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package ahblite_uart_slave_pkg;

    // Register offsets as decoded from HADDR[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;

    // STATUS register bit positions
    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_TX_DONE  = 3;

    // Frame position, shared by the transmitter and the receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable 16-bit down counter that flags the last cycle of a bit period.
// Latency: load takes effect next cycle; tick is combinational from the count.
// Backpressure: none; the counter parks at zero with tick held high.
//
// Ports: HCLK/HRESETn clock and async reset, load + load_val reload the count,
//        tick is high while the count is zero.
module uart_bit_timer (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        tick
);

    logic [15:0] cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= 16'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Loading N-1 makes a period last N cycles, tick marking the final one
    assign tick = (cnt == 16'd0);

endmodule

// File: rtl/ahblite_uart_slave.sv
// AHB-lite UART responder: DATA/STATUS/BAUDDIV registers plus an 8N1 TX and RX.
// Latency: zero wait states; read data is combinational in the data phase.
// Backpressure: none; HREADYOUT is tied high and TX writes while busy are dropped.
//
// Ports: AHB-lite slave (HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
//        HREADYOUT, HRESP, HRDATA), serial TXD/RXD, level interrupt UART_IRQ.
module ahblite_uart_slave
    import ahblite_uart_slave_pkg::*;
#(
    parameter logic [15:0] BAUD_DEFAULT = 16'd868,
    parameter logic [15:0] BAUD_MIN     = 16'd4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        TXD,
    input  logic        RXD,
    output logic        UART_IRQ
);

    // ------------------------------------------------------------------
    // AHB address phase register
    // ------------------------------------------------------------------
    logic       trans_en;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] addr_q;

    assign trans_en = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            addr_q <= 2'd0;
        end else if (trans_en) begin
            wr_en  <= HWRITE;
            rd_en  <= ~HWRITE;
            addr_q <= HADDR[3:2];
        end else begin
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
        end
    end

    logic wr_data;
    logic wr_status;
    logic wr_baud;
    logic rd_data;

    assign wr_data   = wr_en && (addr_q == ADDR_DATA);
    assign wr_status = wr_en && (addr_q == ADDR_STATUS);
    assign wr_baud   = wr_en && (addr_q == ADDR_BAUD);
    assign rd_data   = rd_en && (addr_q == ADDR_DATA);

    // Only the decoded address bits and the used byte lanes matter
    logic unused_bus_bits;
    assign unused_bus_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA[31:16]};

    // ------------------------------------------------------------------
    // Baud divisor
    // ------------------------------------------------------------------
    logic [15:0] baud_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            baud_q <= BAUD_DEFAULT;
        end else if (wr_baud) begin
            baud_q <= (HWDATA[15:0] < BAUD_MIN) ? BAUD_MIN : HWDATA[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e tx_state;
    uart_state_e tx_state_d;
    logic        tx_load;
    logic        tx_tick;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit_cnt;
    logic        tx_busy;
    logic        tx_done_sticky;

    // Reloads sample baud_q at each boundary, so a divisor change
    // applies from the next bit onward.
    uart_bit_timer u_tx_timer (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (tx_load),
        .load_val (baud_q - 16'd1),
        .tick     (tx_tick)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_state <= ST_IDLE;
        end else begin
            tx_state <= tx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_load    = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (wr_data) begin
                    tx_state_d = ST_START;
                    tx_load    = 1'b1;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_state_d = ST_DATA;
                    tx_load    = 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_bit_cnt == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_shift       <= 8'd0;
            tx_bit_cnt     <= 3'd0;
            tx_done_sticky <= 1'b0;
        end else begin
            // A DATA write while busy never reaches the shift register
            if (tx_state == ST_IDLE && wr_data) begin
                tx_shift <= HWDATA[7:0];
            end else if (tx_state == ST_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
            end

            if (tx_state == ST_START && tx_tick) begin
                tx_bit_cnt <= 3'd0;
            end else if (tx_state == ST_DATA && tx_tick) begin
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end

            // Completion outranks a simultaneous W1C
            if (tx_state == ST_STOP && tx_tick) begin
                tx_done_sticky <= 1'b1;
            end else if (wr_status && HWDATA[STAT_TX_DONE]) begin
                tx_done_sticky <= 1'b0;
            end
        end
    end

    assign tx_busy = (tx_state != ST_IDLE);

    // Decoded from state so the line falls back high the moment reset hits
    assign TXD = (tx_state == ST_START) ? 1'b0 :
                 (tx_state == ST_DATA)  ? tx_shift[0] : 1'b1;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic        rx_fall;
    uart_state_e rx_state;
    uart_state_e rx_state_d;
    logic        rx_load;
    logic        rx_tick;
    logic [15:0] rx_load_val;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit_cnt;
    logic        rx_land;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        overrun;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    // Half a period from the falling edge lands on mid-start; whole
    // periods from there keep every later sample at mid-bit.
    assign rx_load_val = (rx_state == ST_IDLE) ? ((baud_q >> 1) - 16'd1)
                                               : (baud_q - 16'd1);

    uart_bit_timer u_rx_timer (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_state <= ST_IDLE;
        end else begin
            rx_state <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_load    = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = ST_START;
                    rx_load    = 1'b1;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (rx_s2) begin
                        // Line already back high at mid-start: a glitch
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_load    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_load = 1'b1;
                    if (rx_bit_cnt == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // A bad stop bit simply never produces rx_land
    assign rx_land = (rx_state == ST_STOP) && rx_tick && rx_s2;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_shift   <= 8'd0;
            rx_bit_cnt <= 3'd0;
            rx_byte    <= 8'd0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_state == ST_START && rx_tick) begin
                rx_bit_cnt <= 3'd0;
            end else if (rx_state == ST_DATA && rx_tick) begin
                rx_shift   <= {rx_s2, rx_shift[7:1]};
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
            end

            // A landing byte beats a concurrent DATA read; overrun only
            // when the old byte was still unread.
            if (rx_land) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end

            if (rx_land && rx_valid && !rd_data) begin
                overrun <= 1'b1;
            end else if (wr_status && HWDATA[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and fixed responses
    // ------------------------------------------------------------------
    always_comb begin
        HRDATA = 32'd0;
        if (rd_en) begin
            case (addr_q)
                ADDR_DATA: HRDATA = {24'd0, rx_byte};
                ADDR_STATUS: begin
                    HRDATA[STAT_TX_BUSY]  = tx_busy;
                    HRDATA[STAT_RX_VALID] = rx_valid;
                    HRDATA[STAT_OVERRUN]  = overrun;
                    HRDATA[STAT_TX_DONE]  = tx_done_sticky;
                end
                ADDR_BAUD: HRDATA = {16'd0, baud_q};
                default:   HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign UART_IRQ  = rx_valid | tx_done_sticky;

endmodule

// File: tb/tb_ahblite_uart_slave.sv
// Directed bench for ahblite_uart_slave: register access, TX waveform,
// RX framing/overrun/glitch handling, divisor clamp and mid-frame reset.
module tb_ahblite_uart_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        TXD;
    logic        RXD;
    logic        UART_IRQ;

    int n_chk = 0;
    int n_bad = 0;

    // Independent TX line decoder (sampled at negedges, mid-bit)
    logic       mon_en   = 1'b1;
    int         mon_baud = 4;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte = 8'd0;
    logic       mon_start = 1'b1;
    logic       mon_stop = 1'b0;

    always #5 HCLK = ~HCLK;

    ahblite_uart_slave dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .TXD       (TXD),
        .RXD       (RXD),
        .UART_IRQ  (UART_IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int baud);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (baud) @(posedge HCLK);
            #1;
        end
        RXD = 1'b1;
        repeat (4) @(posedge HCLK);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            if (mon_en && TXD === 1'b0) begin
                repeat (mon_baud / 2) @(negedge HCLK);
                mon_start = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_baud) @(negedge HCLK);
                    mon_byte[i] = TXD;
                end
                repeat (mon_baud) @(negedge HCLK);
                mon_stop = TXD;
                mon_cnt++;
            end
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        int          cnt0;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1; RXD = 1'b1;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_txd", {31'd0, TXD}, 32'd1);
        check("rst_irq", {31'd0, UART_IRQ}, 32'd0);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h4, rd); check("rst_status", rd, 32'h0);
        ahb_read(32'h8, rd); check("rst_baud", rd, 32'h364);

        // TX of 0x55 at divisor 4, checked every cycle
        ahb_write(32'h8, 32'd4);
        ahb_read(32'h8, rd); check("baud4", rd, 32'd4);
        ahb_write(32'h0, 32'h55);
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 40; c++) begin
            check($sformatf("tx55_c%0d", c), {31'd0, TXD}, {31'd0, frame[c / 4]});
            @(posedge HCLK); #1;
        end
        check("tx55_idle", {31'd0, TXD}, 32'd1);
        ahb_read(32'h4, rd); check("tx55_status_after", rd, 32'h8);
        check("tx55_irq", {31'd0, UART_IRQ}, 32'd1);
        ahb_write(32'h4, 32'h8);
        ahb_read(32'h4, rd); check("tx_done_w1c", rd, 32'h0);
        check("irq_cleared", {31'd0, UART_IRQ}, 32'd0);

        // RX of 0xA3
        send_rx(8'hA3, 1'b1, 4);
        ahb_read(32'h4, rd); check("rxA3_status", rd, 32'h2);
        check("rxA3_irq", {31'd0, UART_IRQ}, 32'd1);
        ahb_read(32'h0, rd); check("rxA3_data", rd, 32'hA3);
        ahb_read(32'h4, rd); check("rxA3_status_clr", rd, 32'h0);

        // Overrun
        send_rx(8'h11, 1'b1, 4);
        send_rx(8'h22, 1'b1, 4);
        ahb_read(32'h4, rd); check("ovr_status", rd, 32'h6);
        ahb_read(32'h0, rd); check("ovr_data", rd, 32'h22);
        ahb_write(32'h4, 32'h4);
        ahb_read(32'h4, rd); check("ovr_w1c", rd, 32'h0);

        // Glitch rejection at divisor 8
        ahb_write(32'h8, 32'd8);
        RXD = 1'b0;
        @(posedge HCLK); #1;
        RXD = 1'b1;
        repeat (20) @(posedge HCLK);
        #1;
        ahb_read(32'h4, rd); check("glitch_status", rd, 32'h0);

        // Framing error leaves a pending byte and flags untouched
        send_rx(8'h77, 1'b1, 8);
        send_rx(8'h5A, 1'b0, 8);
        ahb_read(32'h4, rd); check("frm_status", rd, 32'h2);
        ahb_read(32'h0, rd); check("frm_data", rd, 32'h77);
        ahb_read(32'h4, rd); check("frm_status_clr", rd, 32'h0);

        // Divisor clamp, then a DATA write while busy is dropped
        ahb_write(32'h8, 32'd1);
        ahb_read(32'h8, rd); check("baud_clamp", rd, 32'd4);
        mon_baud = 4;
        cnt0 = mon_cnt;
        ahb_write(32'h0, 32'h3C);
        ahb_read(32'h4, rd); check("busy_status", rd, 32'h1);
        ahb_write(32'h0, 32'h0F);
        for (int i = 0; i < 100 && mon_cnt == cnt0; i++) begin
            @(posedge HCLK); #1;
        end
        check("drop_frames", mon_cnt - cnt0, 32'd1);
        check("drop_start", {31'd0, mon_start}, 32'd0);
        check("drop_byte", {24'd0, mon_byte}, 32'h3C);
        check("drop_stop", {31'd0, mon_stop}, 32'd1);
        repeat (6) @(posedge HCLK);
        #1;
        ahb_read(32'h4, rd); check("drop_status_after", rd, 32'h8);

        // Reset mid-frame
        mon_en = 1'b0;
        ahb_write(32'h0, 32'hAA);
        repeat (6) @(posedge HCLK);
        #1;
        check("midrst_txd_low", {31'd0, TXD}, 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_txd_high", {31'd0, TXD}, 32'd1);
        check("midrst_irq", {31'd0, UART_IRQ}, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h4, rd); check("midrst_status", rd, 32'h0);
        ahb_read(32'h8, rd); check("midrst_baud", rd, 32'h364);
        check("midrst_txd_idle", {31'd0, TXD}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ahblite_uart_slave.md
Name: ahblite_uart_slave

Overview:
AHB-lite responder at the end of the bus-matrix UART output port. It is the target that the UART output-stage arbiter selects. The block decodes the registered address phase, provides zero-wait-state access to data, status and baud registers, and drives a 1-start/8-data/1-stop UART transmitter and receiver. The block is fully synchronous to HCLK.

Parameters:
BAUD_DEFAULT, 16'd868, reset value of the BAUDDIV register (HCLK cycles per bit)
BAUD_MIN, 16'd4, smallest divisor honoured; smaller written values are clamped to it

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from the output stage
HADDR  input  32  address; only [3:2] are decoded
HTRANS  input  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HWRITE  input  1  1=write
HSIZE  input  3  accepted but ignored (byte lanes [7:0]/[15:0] are used)
HWDATA  input  32  write data, sampled in the data phase
HREADY  input  1  bus-level ready
HREADYOUT  output  1  slave ready; constant 1
HRESP  output  1  constant 0 (OKAY)
HRDATA  output  32  read data, valid in the data phase
TXD  output  1  serial transmit line, idle high
RXD  input  1  serial receive line, asynchronous
UART_IRQ  output  1  level interrupt: rx_valid | tx_done_sticky

Behaviour:
- Address phase accept: trans_en = HSEL & HREADY & HTRANS[1]. On trans_en the block registers wr_en=HWRITE, rd_en=~HWRITE and addr_q=HADDR[3:2]. Without trans_en, wr_en and rd_en clear.
- Register map (addr_q):
  - 0 DATA: write loads the TX byte. Read returns {24'b0, rx_byte} and clears rx_valid in the same cycle.
  - 1 STATUS: read returns {28'b0, tx_done_sticky, overrun, rx_valid, tx_busy}. A write of 1 to bit3 or bit2 clears the matching sticky flag (W1C).
  - 2 BAUDDIV: read/write [15:0]. Writes below BAUD_MIN store BAUD_MIN.
  - 3: reads 0, writes are ignored.
- HRDATA is combinational from addr_q and the register state during the data phase, and is 0 when rd_en=0.
- Reset values: TXD=1, HRDATA=0, HREADYOUT=1, HRESP=0, UART_IRQ=0, BAUDDIV=BAUD_DEFAULT, all flags 0, TX/RX FSMs IDLE.
- TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE:
  - Each state holds for BAUDDIV cycles, counted by a 16-bit down counter.
  - A DATA write in IDLE moves the FSM to START on the next cycle and sets tx_busy.
  - A DATA write while tx_busy is dropped silently; the shift register is unchanged.
  - Leaving STOP clears tx_busy and sets tx_done_sticky.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
- RX path:
  - RXD passes through a 2-flop synchronizer (reset value 1).
  - RX FSM IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE detects a synchronized falling edge, then waits BAUDDIV/2 cycles. If the line is high at that point (glitch), the FSM returns to IDLE.
  - Bits are then sampled every BAUDDIV cycles at mid-bit, LSB first.
  - STOP sample =1: load rx_byte and set rx_valid. If rx_valid was already 1, set overrun and overwrite rx_byte.
  - STOP sample =0 (framing error): discard the byte; flags are unchanged.
- Simultaneous events: when a DATA read clears rx_valid in the same cycle a new byte lands, the new byte wins: rx_valid=1, overrun stays 0.
- Reset asserted mid-frame aborts both FSMs immediately. TXD returns high asynchronously.

Decomposition:
- Shared package holds:
  - register offset constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_BAUD=2)
  - STATUS bit indices
  - TX/RX state typedef: 2-bit encodings IDLE/START/DATA/STOP
- One natural sub-module: uart_bit_timer, a loadable 16-bit down counter with a tick at 0. It is instantiated once for TX and once for RX (half-period load for RX start).

Test Plan:
- Reset, then read STATUS and BAUDDIV -> 0x0 and 0x364. TXD=1, UART_IRQ=0.
- Write BAUDDIV=4, then DATA=0x55 -> TXD low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles. STATUS reads 0x1 during the frame and 0x8 after it. UART_IRQ=1.
- BAUDDIV=4, drive RXD with frame 0xA3 -> STATUS=0x2 and UART_IRQ=1. DATA read returns 0x000000A3, then STATUS=0x0.
- Two frames 0x11, 0x22 with no read in between -> STATUS bit2=1 and DATA=0x22. Write STATUS=0x4 -> overrun cleared.
- RXD low pulse of 1 cycle with BAUDDIV=8 -> no byte and rx_valid stays 0. Frame with stop bit 0 -> discarded, flags unchanged.
- Write BAUDDIV=1 -> reads back 4. Write DATA=0x0F while tx_busy -> the transmitted frame is still the first byte. HRESETn pulsed mid-TX -> TXD=1 immediately and STATUS=0.
